mem_array: RTL and testbench



---
 rtl/mem_array.sv | 96 +++++++++
 tb/tb_mem_array.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_array.sv
// rtl/mem_array.sv - parametrised single-port word memory with byte enables and init sequencer
module mem_array #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 16,
  parameter logic [DATA_W-1:0] BOOT_WORD = DATA_W'(32'h000a0209)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  rw,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     in,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     out,
  output logic                  ready,
  output logic                  valid,
  output logic                  err,
  output logic                  busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {INIT, IDLE} state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   out_q;
  logic                valid_q, err_q, ready_q, busy_q;

  logic                accept;
  logic                in_range;
  logic [IDX_W-1:0]    word;

  assign accept   = req && ready_q;
  // Compare one bit wider so DEPTH == 2**ADDR_W is representable.
  assign in_range = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
  assign word     = addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      idx_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        INIT: begin
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DEPTH - 1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (accept) begin
            valid_q <= 1'b1;
            err_q   <= !in_range;
            if (!rw) begin
              out_q <= in_range ? mem_q[word] : '0;
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Storage has no reset; it is cleared by the sequencer once rst is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == INIT) begin
        mem_q[idx_q] <= (idx_q == '0) ? BOOT_WORD : '0;
      end else if (accept && rw && in_range) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem_q[word][8*i +: 8] <= in[8*i +: 8];
        end
      end
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mem_array.sv
// tb/tb_mem_array.sv - scoreboard bench for mem_array (32x16 and 16x4 instances)
module tb_mem_array;

  typedef struct {
    bit          err;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, req1, rw1, ready1, valid1, err1, busy1;
  logic [15:0] addr1;
  logic [31:0] in1, out1;
  logic [3:0]  be1;

  logic        rst2, req2, rw2, ready2, valid2, err2, busy2;
  logic [15:0] addr2;
  logic [15:0] in2, out2;
  logic [1:0]  be2;

  mem_array dut1 (
    .clk(clk), .rst(rst1), .req(req1), .rw(rw1), .addr(addr1), .in(in1), .be(be1),
    .out(out1), .ready(ready1), .valid(valid1), .err(err1), .busy(busy1)
  );

  mem_array #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .BOOT_WORD(16'h0102)) dut2 (
    .clk(clk), .rst(rst2), .req(req2), .rw(rw2), .addr(addr2), .in(in2), .be(be2),
    .out(out2), .ready(ready2), .valid(valid2), .err(err2), .busy(busy2)
  );

  exp_t        q1[$], q2[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [31:0] model [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk_cnt++;
        $display("FAIL spurious_valid1: got valid=1 expected no response at %0t", $time);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("err1", {31'b0, err1}, {31'b0, e.err});
        if (e.chk) check("rdata1", out1, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (valid2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk_cnt++;
        $display("FAIL spurious_valid2: got valid=1 expected no response at %0t", $time);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("err2", {31'b0, err2}, {31'b0, e.err});
        if (e.chk) check("rdata2", {16'b0, out2}, e.data);
      end
    end
  end

  task automatic issue1(input bit w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] b, input bit e, input logic [31:0] x, input bit c);
    exp_t t;
    t.err = e; t.data = x; t.chk = c;
    req1 = 1'b1; rw1 = w; addr1 = a; in1 = d; be1 = b;
    q1.push_back(t);
    @(posedge clk); #1;
    check("latency1", {31'b0, valid1}, 32'd1);
    req1 = 1'b0;
  endtask

  task automatic issue2(input bit w, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] b, input bit e, input logic [31:0] x, input bit c);
    exp_t t;
    t.err = e; t.data = x; t.chk = c;
    req2 = 1'b1; rw2 = w; addr2 = a; in2 = d; be2 = b;
    q2.push_back(t);
    @(posedge clk); #1;
    check("latency2", {31'b0, valid2}, 32'd1);
    req2 = 1'b0;
  endtask

  task automatic count_init(input bit sel, output int n);
    n = 0;
    while (!(sel ? ready2 : ready1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst1 = 1'b0; req1 = 1'b0; rw1 = 1'b0; addr1 = '0; in1 = '0; be1 = '0;
    rst2 = 1'b0; req2 = 1'b0; rw2 = 1'b0; addr2 = '0; in2 = '0; be2 = '0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    model[0] = 32'h000a0209;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready1}, 32'd0);
    check("rst_busy", {31'b0, busy1}, 32'd1);
    check("rst_valid", {31'b0, valid1}, 32'd0);
    check("rst_err", {31'b0, err1}, 32'd0);
    check("rst_out", out1, 32'h0);

    // A request held during INIT must be ignored.
    req1 = 1'b1; rw1 = 1'b0; addr1 = 16'd0;
    rst1 = 1'b1;
    count_init(1'b0, n);
    req1 = 1'b0;
    check("init_cycles", n, 32'd16);
    check("idle_busy", {31'b0, busy1}, 32'd0);

    issue1(0, 16'd0, 0, 0, 0, 32'h000a0209, 1);
    issue1(0, 16'd1, 0, 0, 0, 32'h0, 1);
    issue1(0, 16'd15, 0, 0, 0, 32'h0, 1);

    issue1(1, 16'd5, 32'hDEADBEEF, 4'b1111, 0, 0, 0);
    issue1(1, 16'd5, 32'h11223344, 4'b0101, 0, 0, 0);
    issue1(0, 16'd5, 0, 0, 0, 32'hDE22BE44, 1);
    model[5] = 32'hDE22BE44;

    issue1(0, 16'd3, 0, 0, 0, 32'h0, 1);
    issue1(1, 16'd3, 32'hA5A5A5A5, 4'b1111, 0, 0, 0);
    issue1(0, 16'd3, 0, 0, 0, 32'hA5A5A5A5, 1);
    model[3] = 32'hA5A5A5A5;

    issue1(1, 16'd7, 32'h99999999, 4'b0000, 0, 0, 0);

    issue1(0, 16'd16, 0, 0, 1, 32'h0, 1);
    issue1(1, 16'hFFFF, 32'hFFFFFFFF, 4'b1111, 1, 0, 0);
    for (int i = 0; i < 16; i++) issue1(0, 16'(i), 0, 0, 0, model[i], 1);

    // Reset in IDLE: the request presented at the reset edge is dropped.
    issue1(1, 16'd0, 32'h12345678, 4'b1111, 0, 0, 0);
    req1 = 1'b1; rw1 = 1'b1; addr1 = 16'd1; in1 = 32'hFFFFFFFF; be1 = 4'b1111;
    rst1 = 1'b0;
    @(posedge clk); #1;
    check("rst_idle_valid", {31'b0, valid1}, 32'd0);
    check("rst_idle_ready", {31'b0, ready1}, 32'd0);
    req1 = 1'b0;
    rst1 = 1'b1;
    count_init(1'b0, n);
    check("reinit_cycles", n, 32'd16);
    issue1(0, 16'd0, 0, 0, 0, 32'h000a0209, 1);
    issue1(0, 16'd1, 0, 0, 0, 32'h0, 1);

    rst1 = 1'b0;
    @(posedge clk); #1;
    rst1 = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst1 = 1'b0;
    @(posedge clk); #1;
    rst1 = 1'b1;
    count_init(1'b0, n);
    check("restart_cycles", n, 32'd16);
    issue1(0, 16'd5, 0, 0, 0, 32'h0, 1);
    issue1(0, 16'd3, 0, 0, 0, 32'h0, 1);

    rst2 = 1'b1;
    count_init(1'b1, n);
    check("init2_cycles", n, 32'd4);
    check("idle2_busy", {31'b0, busy2}, 32'd0);
    issue2(0, 16'd0, 0, 0, 0, 32'h0102, 1);
    issue2(0, 16'd3, 0, 0, 0, 32'h0, 1);
    issue2(0, 16'd4, 0, 0, 1, 32'h0, 1);
    issue2(1, 16'd1, 16'hABCD, 2'b10, 0, 0, 0);
    issue2(0, 16'd1, 0, 0, 0, 32'hAB00, 1);

    repeat (3) @(posedge clk);
    check("q1_drained", q1.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
